// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one downstream bus port between NrHosts hosts.
// Issued host indices are queued in order so each response returns to its issuer.
module bus_host_arbiter #(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                              clk_sys_i,
  input  logic                              rst_sys_ni,
  input  logic [NrHosts-1:0]                host_req_i,
  output logic [NrHosts-1:0]                host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                host_we_i,
  input  logic [NrHosts*4-1:0]              host_be_i,
  input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                host_rvalid_o,
  output logic [DataWidth-1:0]              host_rdata_o,
  output logic [NrHosts-1:0]                host_err_o,
  output logic                              dev_req_o,
  input  logic                              dev_gnt_i,
  output logic [AddressWidth-1:0]           dev_addr_o,
  output logic                              dev_we_o,
  output logic [3:0]                        dev_be_o,
  output logic [DataWidth-1:0]              dev_wdata_o,
  input  logic                              dev_rvalid_i,
  input  logic [DataWidth-1:0]              dev_rdata_i,
  input  logic                              dev_err_i,
  output logic                              unexp_rsp_o
);

  localparam int unsigned IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   lock_q, lock_d;
  logic [IdxW-1:0]   fifo_q [MaxOutstanding];
  logic [IdxW-1:0]   fifo_d [MaxOutstanding];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              unexp_q, unexp_d;

  logic [IdxW-1:0]   rr_idx, cand, sel, head;
  logic              found, dev_req, push, pop, full, empty;

  // Full is taken from the registered count, so a pop never frees a slot in the same cycle.
  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  always_comb begin
    rr_idx = ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < int'(NrHosts); i++) begin
      cand = IdxW'((int'(ptr_q) + i) % int'(NrHosts));
      if (!found && host_req_i[cand]) begin
        rr_idx = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    sel     = rr_idx;
    dev_req = 1'b0;
    case (state_q)
      IDLE: begin
        dev_req = (|host_req_i) & ~full;
        if (dev_req && !dev_gnt_i) begin
          state_d = LOCK;
          lock_d  = rr_idx;
        end
      end
      LOCK: begin
        // Hold the presented request until granted; a dropped request is abandoned.
        sel     = lock_q;
        dev_req = host_req_i[lock_q];
        if (dev_gnt_i || !host_req_i[lock_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    push = dev_req & dev_gnt_i;
    pop  = dev_rvalid_i & ~empty;
    if (push) ptr_d = (sel == IdxW'(NrHosts - 1)) ? '0 : sel + 1'b1;
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    unexp_d  = unexp_q | (dev_rvalid_i & empty);
    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      lock_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      unexp_q  <= 1'b0;
      for (int i = 0; i < int'(MaxOutstanding); i++) fifo_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      lock_q   <= lock_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      unexp_q  <= unexp_d;
      fifo_q   <= fifo_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    dev_req_o     = 1'b0;
    dev_addr_o    = '0;
    dev_we_o      = 1'b0;
    dev_be_o      = '0;
    dev_wdata_o   = '0;
    if (rst_sys_ni) begin
      host_gnt_o[sel]     = push;
      host_rvalid_o[head] = pop;
      host_err_o[head]    = pop & dev_err_i;
      host_rdata_o        = dev_rdata_i;
      dev_req_o           = dev_req;
      dev_addr_o          = host_addr_i[sel*AddressWidth +: AddressWidth];
      dev_we_o            = host_we_i[sel];
      dev_be_o            = host_be_i[sel*4 +: 4];
      dev_wdata_o         = host_wdata_i[sel*DataWidth +: DataWidth];
    end
  end

  assign unexp_rsp_o = unexp_q;

endmodule
